// File: rtl/dmem_lsu_if.sv
// Bundle of CPU request/response and data-memory pins around the load/store unit.
// The slave view belongs to the LSU; the master view is the CPU plus memory side.
interface dmem_lsu_if #(
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;

    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    logic [AW-1:0] mem_a;
    logic [31:0]   mem_d;
    logic          mem_we;
    logic [31:0]   mem_spo;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_spo,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_d, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_spo,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_d, mem_we
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit for a word-addressed single-port memory with combinational read:
// sub-word load extraction/extension, read-modify-write sub-word stores, access checks.
module dmem_lsu #(
    parameter int AW = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    dmem_lsu_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_e        state_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    off_q;
    logic [15:0]   wdata_q;
    logic [AW-1:0] mem_a_q;
    logic [31:0]   merge_q;
    logic          mem_we_q;
    logic          resp_valid_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          accept;
    logic          req_err;
    logic [AW-1:0] req_idx;
    logic [7:0]    lane_byte;
    logic [15:0]   lane_half;
    logic [31:0]   load_data;
    logic [31:0]   merge_d;

    assign bus.req_ready  = rst_n && (state_q == S_IDLE);
    assign accept         = bus.req_valid && bus.req_ready;
    assign req_idx        = bus.req_addr[AW+1:2];

    assign bus.mem_a      = mem_a_q;
    assign bus.mem_d      = merge_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Upper address bits beyond the memory's byte range count as out of range.
    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == SZ_ILL)
            req_err = 1'b1;
        else if (bus.req_addr[31:AW+2] != '0)
            req_err = 1'b1;
        else if (bus.req_size == SZ_HALF && bus.req_addr[0])
            req_err = 1'b1;
        else if (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
            req_err = 1'b1;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lane_byte = 8'h00;
        lane_half = off_q[1] ? bus.mem_spo[31:16] : bus.mem_spo[15:0];
        load_data = bus.mem_spo;
        case (off_q)
            2'd0: lane_byte = bus.mem_spo[7:0];
            2'd1: lane_byte = bus.mem_spo[15:8];
            2'd2: lane_byte = bus.mem_spo[23:16];
            2'd3: lane_byte = bus.mem_spo[31:24];
            default: lane_byte = 8'h00;
        endcase
        case (size_q)
            SZ_BYTE: load_data = {{24{~uns_q & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{~uns_q & lane_half[15]}}, lane_half};
            default: load_data = bus.mem_spo;
        endcase
    end

    // Splice the stored lane into the current memory word; other lanes pass through.
    always_comb begin
        merge_d = bus.mem_spo;
        if (size_q == SZ_BYTE) begin
            case (off_q)
                2'd0: merge_d[7:0]   = wdata_q[7:0];
                2'd1: merge_d[15:8]  = wdata_q[7:0];
                2'd2: merge_d[23:16] = wdata_q[7:0];
                2'd3: merge_d[31:24] = wdata_q[7:0];
                default: merge_d = bus.mem_spo;
            endcase
        end else if (off_q[1]) begin
            merge_d[31:16] = wdata_q;
        end else begin
            merge_d[15:0] = wdata_q;
        end
    end

    // NOTE: datapath registers are reset too, because every bus output must read 0 out of reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            mem_a_q      <= '0;
            merge_q      <= '0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        off_q   <= bus.req_addr[1:0];
                        wdata_q <= bus.req_wdata[15:0];
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        if (req_err) begin
                            err_q        <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (!bus.req_we) begin
                            mem_a_q <= req_idx;
                            state_q <= S_LOAD;
                        end else if (bus.req_size == SZ_WORD) begin
                            mem_a_q  <= req_idx;
                            merge_q  <= bus.req_wdata;
                            mem_we_q <= 1'b1;
                            state_q  <= S_WRITE;
                        end else begin
                            mem_a_q <= req_idx;
                            state_q <= S_MERGE;
                        end
                    end
                end
                S_LOAD: begin
                    rdata_q      <= load_data;
                    mem_a_q      <= '0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_MERGE: begin
                    merge_q  <= merge_d;
                    mem_we_q <= 1'b1;
                    state_q  <= S_WRITE;
                end
                S_WRITE: begin
                    mem_we_q     <= 1'b0;
                    mem_a_q      <= '0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a behavioural 256x32 memory, expected responses and
// writes queued at acceptance, compared with cycle timing when the DUT produces them.
module tb_dmem_lsu;

    localparam int AW = 8;
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_lsu_if #(.AW(AW)) bus ();

    dmem_lsu #(.AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [256] = '{default: 32'h0};
    assign bus.mem_spo = mem[bus.mem_a];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_a] <= bus.mem_d;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } resp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        int            at;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];
    resp_t er;
    wr_t   ew;

    int n_vec = 0;
    int n_err = 0;
    bit busy = 1'b0;
    int last_resp = -100;
    int t_acc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) check("ready_while_busy", 32'(bus.req_ready), 32'd0);
            if (bus.resp_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    er = rq.pop_front();
                    check("resp_rdata", bus.resp_rdata, er.rdata);
                    check("resp_err", 32'(bus.resp_err), 32'(er.err));
                    check("resp_cycle", 32'(cyc), 32'(er.at));
                end
                busy = 1'b0;
                last_resp = cyc;
            end
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_mem_we", 32'd1, 32'd0);
                end else begin
                    ew = wq.pop_front();
                    check("mem_a", 32'(bus.mem_a), 32'(ew.a));
                    check("mem_d", bus.mem_d, ew.d);
                    check("mem_we_cycle", 32'(cyc), 32'(ew.at));
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic [31:0] exp_wd, input bit hold, input bit b2b);
        int guard;
        int lat;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        guard = 0;
        while (!bus.req_ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        t_acc = cyc;
        if (b2b) check("b2b_accept_cycle", 32'(t_acc), 32'(last_resp + 2));
        if (!hold) bus.req_valid = 1'b0;
        if (exp_err)              lat = 1;
        else if (!we || size == W) lat = 2;
        else                      lat = 3;
        rq.push_back('{exp_rd, exp_err, t_acc + lat - 1});
        if (we && !exp_err) wq.push_back('{addr[AW+1:2], exp_wd, t_acc + lat - 2});
        busy = 1'b1;
    endtask

    task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                      input logic [31:0] exp_rd);
        do_req(1'b0, size, uns, addr, 32'h0, exp_rd, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic st(input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_wd);
        do_req(1'b1, size, 1'b0, addr, wdata, 32'h0, 1'b0, exp_wd, 1'b0, 1'b0);
    endtask

    task automatic bad(input logic we, input logic [1:0] size, input logic [31:0] addr);
        do_req(we, size, 1'b0, addr, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((rq.size() != 0 || wq.size() != 0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 32'(rq.size() + wq.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = B;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_a", 32'(bus.mem_a), 32'd0);
        check("rst_mem_d", bus.mem_d, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.req_ready), 32'd1);

        // word store then load
        st(W, 32'h010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        ld(W, 1'b0, 32'h010, 32'hDEAD_BEEF);

        // read-modify-write sub-word stores; upper wdata bits must be ignored
        st(W, 32'h020, 32'h1122_3344, 32'h1122_3344);
        st(B, 32'h022, 32'hFFFF_FFAB, 32'h11AB_3344);
        st(H, 32'h020, 32'h1234_CAFE, 32'h11AB_CAFE);
        ld(W, 1'b1, 32'h020, 32'h11AB_CAFE);

        // extraction and extension
        st(W, 32'h030, 32'h80FF_7F80, 32'h80FF_7F80);
        ld(B, 1'b0, 32'h030, 32'hFFFF_FF80);
        ld(B, 1'b1, 32'h030, 32'h0000_0080);
        ld(H, 1'b0, 32'h032, 32'hFFFF_80FF);
        ld(H, 1'b1, 32'h032, 32'h0000_80FF);
        ld(B, 1'b0, 32'h031, 32'h0000_007F);
        ld(H, 1'b0, 32'h030, 32'h0000_7F80);
        ld(B, 1'b0, 32'h033, 32'hFFFF_FF80);

        // errors: no memory write, one-cycle latency
        bad(1'b0, H, 32'h001);
        bad(1'b1, W, 32'h006);
        bad(1'b0, X, 32'h000);
        bad(1'b0, W, 32'h400);
        bad(1'b1, B, 32'h8000_0010);
        bad(1'b1, H, 32'h0000_0023);

        // last legal byte address
        st(B, 32'h3FF, 32'h0000_005A, 32'h5A00_0000);
        ld(B, 1'b1, 32'h3FF, 32'h0000_005A);
        ld(W, 1'b0, 32'h3FC, 32'h5A00_0000);
        wait_idle();
        check("mem_a_idle", 32'(bus.mem_a), 32'd0);

        // back-to-back loads with req_valid held high
        do_req(1'b0, W, 1'b0, 32'h010, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 1'b0);
        do_req(1'b0, W, 1'b0, 32'h020, 32'h0, 32'h11AB_CAFE, 1'b0, 32'h0, 1'b1, 1'b1);
        do_req(1'b0, W, 1'b0, 32'h030, 32'h0, 32'h80FF_7F80, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_idle();

        // reset during MERGE of a byte store aborts it silently
        st(W, 32'h040, 32'h5566_7788, 32'h5566_7788);
        wait_idle();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = B;
        bus.req_addr  = 32'h041;
        bus.req_wdata = 32'h0000_0099;
        check("ready_before_abort", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        #1 rst_n = 1'b0;
        busy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_mem_we", 32'(bus.mem_we), 32'd0);
            check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
            check("abort_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 32'(bus.req_ready), 32'd1);
        repeat (3) @(negedge clk);
        ld(W, 1'b0, 32'h040, 32'h5566_7788);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting between the CPU datapath and the 256×32 single-port data memory (word-addressed, combinational read, no byte enables). It accepts one load or store request at a time over a valid/ready handshake and drives the memory's address, write-data and write-enable pins. It performs byte/halfword extraction with sign or zero extension, and read-modify-write merging for sub-word stores. It flags misaligned and out-of-range accesses without touching memory.

## Interface

- `AW`, default 8: memory word-address width; valid byte range is `0 .. 2^(AW+2)-1` (0x000–0x3FF at default).
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  unit can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word; 11 is illegal (error).
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the value sits in the low bits for sub-word stores.
- `resp_valid`  out  1  one-cycle pulse: request complete.
- `resp_rdata`  out  32  load result, valid with `resp_valid`; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`: misaligned, out of range, or illegal size.
- `mem_a`  out  AW  memory word address (`addr[AW+1:2]`).
- `mem_d`  out  32  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_spo`  in  32  memory combinational read data for `mem_a`.

## Operation

- Requests use a valid/ready handshake. A request is accepted when `req_valid && req_ready`. All request fields are latched at acceptance.
- `req_ready` = 1 only in IDLE and only while `rst_n` is high.
- There is no response backpressure. The CPU must take `resp_valid` when it is asserted.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k], and the halfword at offset 2 occupies [31:16].
- Error checks are evaluated at acceptance, in this priority:
  - `req_size`==11
  - address ≥ 2^(AW+2)
  - half with `addr[0]`≠0
  - word with `addr[1:0]`≠0
- An erroring request never asserts `mem_we`.
- FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
  - IDLE → RESP on an accepted request that errors. `err_r`=1 is set.
  - IDLE → LOAD on an accepted load.
  - IDLE → WRITE on an accepted word store. The merge register is loaded with `req_wdata`.
  - IDLE → MERGE on an accepted byte or half store.
  - LOAD → RESP. The `mem_spo` lane is extracted, extended, and registered into `resp_rdata`.
  - MERGE → WRITE. The new lane from `req_wdata` is spliced into `mem_spo`; untouched lanes are preserved. The result is registered.
  - WRITE → RESP. `mem_we`=1 for exactly this one cycle, with `mem_d` = merged word.
  - RESP → IDLE. `resp_valid`=1 for exactly one cycle; `resp_rdata`/`resp_err` hold their registered values.
- `mem_a` holds the latched word index from LOAD through WRITE. It is 0 in IDLE.
- Extension rules:
  - Signed byte: bit 7 is replicated into [31:8].
  - Signed half: bit 15 is replicated into [31:16].
  - Unsigned forms fill the upper bits with 0.
  - `req_unsigned` is ignored for stores and word loads.

## Timing

- Outputs while `rst_n` is low, and out of reset:
  - `req_ready`=0 while `rst_n` is low.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `mem_we`=0, `mem_a`=0, `mem_d`=0.
  - State = IDLE.
- `req_ready` rises in the first cycle after `rst_n` deasserts.
- Latency from the acceptance edge T to `resp_valid`:
  - Error: high in cycle T+1.
  - Load: T+2.
  - Word store: T+2, with `mem_we` in T+1.
  - Sub-word store: T+3, with `mem_we` in T+2.
- Throughput: next acceptance earliest in the cycle after `resp_valid`. `req_ready` is 0 from T+1 through the RESP cycle.
- Reset asserted mid-operation, including during MERGE or WRITE, returns to IDLE immediately with `mem_we` forced to 0. No partial write occurs after reset assertion, and no response is generated for the aborted request.
- The last legal address (0x3FF at default) is in range. Address 0x400 errors, as do upper address bits [31:AW+2] ≠ 0.

## Test plan

- Word store 0xDEADBEEF @0x010, then word load @0x010 → `mem_we` pulse with `mem_a`=4, `mem_d`=0xDEADBEEF; load returns 0xDEADBEEF, `resp_err`=0, latency 2 cycles each.
- Memory word @0x020 = 0x11223344; byte store 0xAB @0x022 → exactly one `mem_we` at T+2 with `mem_d`=0x11AB3344; half store 0xCAFE @0x020 then → 0x11ABCAFE.
- Word 0x80FF7F80 @0x030: signed byte load @0x030 → 0xFFFFFF80; unsigned → 0x00000080; signed half @0x032 → 0xFFFF80FF; signed byte @0x031 → 0x0000007F.
- Half load @0x001, word store @0x006, size 11 @0x000, word load @0x400 → each returns `resp_valid` at T+1 with `resp_err`=1, `resp_rdata`=0, and no `mem_we`.
- Back-to-back: `req_valid` held high with three loads → `req_ready` low between them; each accepted only the cycle after the previous `resp_valid`; responses in order.
- Reset mid sub-word store, with `rst_n` pulled low during MERGE → `mem_we` never asserts, memory word unchanged, no `resp_valid`; `req_ready`=1 the first cycle after release.
